// File: rtl/ex_mem_skid_register_pkg.sv
// Shared EX/MEM pipeline definitions: skid register state encoding, payload
// field widths and the memory-stage control encodings.
package ex_mem_skid_register_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } skid_state_e;

    localparam int DATA_FIELDS = 5;
    localparam int REGDST_W    = 5;
    localparam int FLAGS_W     = 5;
    localparam int MEMTOREG_W  = 2;
    localparam int DECODEOP_W  = 2;
    localparam int CTRL_W      = REGDST_W + FLAGS_W + MEMTOREG_W + DECODEOP_W;

    localparam logic [MEMTOREG_W-1:0] MEMTOREG_ALU  = 2'd0;
    localparam logic [MEMTOREG_W-1:0] MEMTOREG_MEM  = 2'd1;
    localparam logic [MEMTOREG_W-1:0] MEMTOREG_LINK = 2'd2;

    localparam logic [DECODEOP_W-1:0] DECODEOP_RTYPE  = 2'd0;
    localparam logic [DECODEOP_W-1:0] DECODEOP_ITYPE  = 2'd1;
    localparam logic [DECODEOP_W-1:0] DECODEOP_JUMP   = 2'd2;
    localparam logic [DECODEOP_W-1:0] DECODEOP_BRANCH = 2'd3;

    function automatic int payload_width(input int data_w);
        return DATA_FIELDS * data_w + CTRL_W;
    endfunction

endpackage

// File: rtl/ex_mem_skid_register_payload_reg.sv
// Payload-width holding register with load enable and asynchronous clear;
// used for both the main and the skid entry.
module pipe_payload_reg
    import ex_mem_skid_register_pkg::*;
#(
    parameter int W = payload_width(32)
) (
    input  logic         i_clk,
    input  logic         i_clr,
    input  logic         i_load,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    always_ff @(posedge i_clk or posedge i_clr) begin
        if (i_clr) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/ex_mem_skid_register.sv
// EX/MEM pipeline register with a two-entry skid buffer so that in_ready is a
// flop and never depends combinationally on the memory stage's out_ready.
module ex_mem_skid_register
    import ex_mem_skid_register_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] ALU_result,
    input  logic [DATA_W-1:0] reg_data2,
    input  logic [DATA_W-1:0] pc,
    input  logic [DATA_W-1:0] BranchTarget,
    input  logic [DATA_W-1:0] JumpRegisterTarget,
    input  logic [4:0]        regdst,
    input  logic              Zero,
    input  logic              branch,
    input  logic              regwrite,
    input  logic              memwrite,
    input  logic              memread,
    input  logic [1:0]        memtoreg,
    input  logic [1:0]        decodeop,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] ALU_result_out,
    output logic [DATA_W-1:0] reg_data2_out,
    output logic [DATA_W-1:0] pc_out,
    output logic [DATA_W-1:0] BranchTarget_out,
    output logic [DATA_W-1:0] JumpRegisterTarget_out,
    output logic [4:0]        regdst_out,
    output logic              Zero_out,
    output logic              branch_out,
    output logic              regwrite_out,
    output logic              memwrite_out,
    output logic              memread_out,
    output logic [1:0]        memtoreg_out,
    output logic [1:0]        decodeop_out,
    input  logic              flush,
    output logic              branch_taken
);

    localparam int PW = payload_width(DATA_W);

    skid_state_e r_state;
    skid_state_e w_state_nxt;
    logic        r_in_ready;
    logic        r_out_valid;

    logic          w_accept;
    logic          w_issue;
    logic          w_main_load;
    logic          w_skid_load;
    logic [PW-1:0] w_in_payload;
    logic [PW-1:0] w_main_d;
    logic [PW-1:0] w_main_q;
    logic [PW-1:0] w_skid_q;

    assign w_accept = in_valid & r_in_ready;
    assign w_issue  = r_out_valid & out_ready;

    assign w_in_payload = {ALU_result, reg_data2, pc, BranchTarget, JumpRegisterTarget,
                           regdst, Zero, branch, regwrite, memwrite, memread,
                           memtoreg, decodeop};

    // Flush wins over everything and suppresses loads so EMPTY keeps the last payload.
    always_comb begin
        w_state_nxt = r_state;
        w_main_load = 1'b0;
        w_skid_load = 1'b0;
        w_main_d    = w_in_payload;
        if (flush) begin
            w_state_nxt = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        w_main_load = 1'b1;
                        w_state_nxt = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_accept && w_issue) begin
                        w_main_load = 1'b1;
                    end else if (w_accept) begin
                        w_skid_load = 1'b1;
                        w_state_nxt = ST_FULL;
                    end else if (w_issue) begin
                        w_state_nxt = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (w_issue) begin
                        w_main_load = 1'b1;
                        w_main_d    = w_skid_q;
                        w_state_nxt = ST_ONE;
                    end
                end
                default: begin
                    w_state_nxt = ST_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state     <= ST_EMPTY;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_out_valid <= (w_state_nxt != ST_EMPTY);
            r_in_ready  <= (w_state_nxt != ST_FULL);
        end
    end

    pipe_payload_reg #(.W(PW)) u_main (
        .i_clk  (Clk),
        .i_clr  (Rst),
        .i_load (w_main_load),
        .i_d    (w_main_d),
        .o_q    (w_main_q)
    );

    pipe_payload_reg #(.W(PW)) u_skid (
        .i_clk  (Clk),
        .i_clr  (Rst),
        .i_load (w_skid_load),
        .i_d    (w_in_payload),
        .o_q    (w_skid_q)
    );

    assign {ALU_result_out, reg_data2_out, pc_out, BranchTarget_out, JumpRegisterTarget_out,
            regdst_out, Zero_out, branch_out, regwrite_out, memwrite_out, memread_out,
            memtoreg_out, decodeop_out} = w_main_q;

    assign in_ready     = r_in_ready;
    assign out_valid    = r_out_valid;
    assign branch_taken = r_out_valid & branch_out & Zero_out;

endmodule

// File: doc/ex_mem_skid_register.md
EX_MEM_SKID_REGISTER -- requirements
Module: ex_mem_skid_register

Interface
REQ-001 Parameter DATA_W, default 32: width of the ALU result, store data, PC, branch target and jump register target fields.
REQ-002 Clk  in  1  sole clock; all state updates on the rising edge.
REQ-003 Rst  in  1  asynchronous, active-high reset.
REQ-004 in_valid  in  1  execute stage presents a valid instruction this cycle.
REQ-005 in_ready  out  1  register can accept an instruction this cycle.
REQ-006 ALU_result, reg_data2, pc, BranchTarget, JumpRegisterTarget  in  DATA_W each  execute-stage data payload.
REQ-007 regdst  in  5  destination register; Zero, branch, regwrite, memwrite, memread  in  1 each; memtoreg, decodeop  in  2 each  execute-stage control payload.
REQ-008 out_valid  out  1  memory stage is presented a valid instruction.
REQ-009 out_ready  in  1  memory stage accepts the presented instruction.
REQ-010 Every payload input SHALL have a same-width, same-meaning output with the _out suffix.
REQ-011 flush  in  1  discard all held instructions.
REQ-012 branch_taken  out  1  high when out_valid & branch_out & Zero_out.

Function
REQ-013 Accept event: in_valid & in_ready. Issue event: out_valid & out_ready.
REQ-014 Storage SHALL be two entries: main (drives outputs) and skid. States: EMPTY (none valid), ONE (main valid), FULL (main and skid valid).
REQ-015 in_ready SHALL equal 1 in EMPTY and ONE, and 0 in FULL. It SHALL be driven from a flop, with no combinational path from out_ready.
REQ-016 EMPTY: on accept, load main and go to ONE.
REQ-017 ONE, accept without issue: load skid and go to FULL.
REQ-018 ONE, accept with issue: load main with the new payload and stay in ONE.
REQ-019 ONE, issue without accept: go to EMPTY.
REQ-020 FULL, issue: copy skid to main and go to ONE. There is no accept in FULL.
REQ-021 Held payload SHALL stay stable while out_valid=1 and out_ready=0.
REQ-022 Order SHALL be FIFO. An accepted instruction SHALL never be dropped or duplicated except by flush.
REQ-023 Latency: an instruction accepted at edge N SHALL present out_valid=1 after edge N when the register was EMPTY. Throughput SHALL be 1 per cycle with out_ready held high.
REQ-024 flush SHALL clear both entries at the next edge, go to EMPTY, and take priority over a simultaneous accept or issue. The accepted instruction is discarded.
REQ-025 In EMPTY, payload outputs SHALL retain their last value. Consumers SHALL qualify them with out_valid.
REQ-026 branch_taken SHALL be combinational from the main entry only.

Reset
REQ-027 While Rst=1, state SHALL be EMPTY, out_valid=0, in_ready=1, and all payload outputs and the skid entry SHALL be 0.
REQ-028 Rst asserted mid-transfer SHALL discard both entries immediately, without waiting for a clock edge.
REQ-029 The first accept after Rst deasserts SHALL be honoured at the first rising edge.

Structure
REQ-030 A shared pipeline package SHALL hold: the state encoding (EMPTY=2'd0, ONE=2'd1, FULL=2'd2), the ex_mem payload field widths, and the MEMTOREG and DECODEOP encodings.
REQ-031 The payload SHALL be treated as one 174-bit vector (at DATA_W=32) inside the block.
REQ-032 One sub-module, pipe_payload_reg, SHALL be used twice (main and skid). It is a payload-width register with load enable and async clear.
REQ-033 Implementation SHALL be 120-400 lines of RTL and contain no latches.

Verification
REQ-034 Reset: Rst=1 mid-stream -> out_valid=0, in_ready=1, ALU_result_out=0 with no clock edge; first accept after release appears next cycle.
REQ-035 Streaming: 8 instructions, ALU_result 1..8, out_ready=1 -> outputs 1..8 on consecutive cycles; in_ready stays 1.
REQ-036 Backpressure:
  - out_ready=0 with ALU_result 0x10 then 0x20 accepted -> FULL, in_ready=0, output holds 0x10.
  - out_ready=1 -> 0x10, then 0x20 on the next cycle; in_ready returns to 1.
REQ-037 Flush: flush=1 in FULL together with in_valid=1 (0x30) -> EMPTY next cycle, out_valid=0; 0x30 never appears at the output.
REQ-038 Branch: branch=1, Zero=1, BranchTarget=0x40 accepted -> branch_taken=1 and BranchTarget_out=0x40 while presented; Zero=0 gives branch_taken=0.
REQ-039 Random in_valid and out_ready for 10k cycles -> scoreboard shows in-order, lossless transfer and stable payload under stall.
